pc_ir_unit: RTL and testbench

- Architectural state consumed directly downstream of the multicycle control FSM: program counter, PC_OLD, instruction register (IR), branch-condition evaluation and immediate generation.
- Acts on the FSM's registered pc_update, branch and inst_en strobes.
- Feeds opcode back to the FSM and fields, immediate, PC and PC_OLD to the datapath.

---
 rtl/pc_ir_unit_pkg.sv | 40 ++++
 rtl/pc_ir_unit_if.sv | 38 +++
 rtl/pc_ir_unit_imm_gen.sv | 30 +++
 rtl/pc_ir_unit.sv | 96 +++++++++
 tb/tb_pc_ir_unit.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_ir_unit_pkg.sv
// Opcode constants, branch funct3 encodings and branch-condition helper shared with the control FSM.
// Purely declarative; no state.
package pc_ir_unit_pkg;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STYPE = 7'b0100011;
   localparam logic [6:0] OP_BTYPE = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } branch_funct3_t;

   // funct3 values 010/011 are not branches and never take.
   function automatic logic branch_cond(input logic [2:0] f3, input logic zero,
                                        input logic lt, input logic ltu);
      logic c;
      case (f3)
         BEQ:     c = zero;
         BNE:     c = !zero;
         BLT:     c = lt;
         BGE:     c = !lt;
         BLTU:    c = ltu;
         BGEU:    c = !ltu;
         default: c = 1'b0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pc_ir_unit_if.sv
// Bundle between the control FSM/datapath (master) and the PC/IR unit (slave).
// Master drives strobes, result, ALU flags and memory read data; slave returns PC/IR state.
interface pc_ir_unit_if;
   logic        pc_update;
   logic        branch;
   logic        inst_en;
   logic [31:0] result;
   logic        alu_zero;
   logic        alu_lt;
   logic        alu_ltu;
   logic [31:0] mem_rd_data;

   logic [31:0] pc;
   logic [31:0] pc_old;
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [31:0] imm;
   logic        taken;
   logic        misalign_err;
   logic [31:0] instret;

   modport master (
      output pc_update, branch, inst_en, result, alu_zero, alu_lt, alu_ltu, mem_rd_data,
      input  pc, pc_old, instr, opcode, funct3, funct7, rs1, rs2, rd, imm, taken,
             misalign_err, instret
   );

   modport slave (
      input  pc_update, branch, inst_en, result, alu_zero, alu_lt, alu_ltu, mem_rd_data,
      output pc, pc_old, instr, opcode, funct3, funct7, rs1, rs2, rd, imm, taken,
             misalign_err, instret
   );
endinterface

// File: rtl/pc_ir_unit_imm_gen.sv
// RV32I immediate generator: sign-extended immediate selected by opcode.
// Purely combinational, zero latency.
module pc_ir_unit_imm_gen
   import pc_ir_unit_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [31:0] imm_o
);

   always_comb begin
      imm_o = '0;
      case (instr_i[6:0])
         OP_ITYPE, OP_LOAD, OP_JALR:
            imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
         OP_STYPE:
            imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         OP_BTYPE:
            imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                     instr_i[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm_o = {instr_i[31:12], 12'b0};
         OP_JAL:
            imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                     instr_i[30:21], 1'b0};
         default:
            imm_o = '0;
      endcase
   end

endmodule

// File: rtl/pc_ir_unit.sv
// PC, PC_OLD, IR, branch evaluation and decode fields acting on the FSM's registered strobes.
// State updates in one cycle; instr bypasses memory data in the DECODE cycle (zero latency).
module pc_ir_unit
   import pc_ir_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic         clk,
   input  logic         reset,
   pc_ir_unit_if.slave  bus
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_old_q, pc_old_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] instret_q, instret_d;
   logic        fetch_q, fetch_d;
   logic        taken_q, taken_d;
   logic        misalign_q, misalign_d;
   logic        pc_load;
   logic [31:0] instr;

   // Memory data is valid the cycle after the fetch address, before IR captures it.
   assign instr = fetch_q ? bus.mem_rd_data : ir_q;

   always_comb begin
      pc_d       = pc_q;
      pc_old_d   = pc_old_q;
      ir_d       = ir_q;
      instret_d  = instret_q;
      fetch_d    = bus.inst_en;
      taken_d    = taken_q;
      misalign_d = misalign_q;
      pc_load    = 1'b0;

      if (bus.pc_update) begin
         pc_load = 1'b1;
         if (bus.branch) taken_d = 1'b0;
      end else if (bus.branch) begin
         taken_d = branch_cond(instr[14:12], bus.alu_zero, bus.alu_lt, bus.alu_ltu);
         pc_load = taken_d;
      end

      if (pc_load) begin
         pc_d = bus.result & 32'hFFFF_FFFC;
         if (bus.result[1]) misalign_d = 1'b1;
      end

      if (bus.inst_en) begin
         pc_old_d  = pc_q;
         instret_d = instret_q + 32'd1;
      end

      if (fetch_q) ir_d = bus.mem_rd_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         pc_old_q   <= RESET_PC;
         ir_q       <= NOP_INSTR;
         instret_q  <= '0;
         fetch_q    <= 1'b0;
         taken_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         pc_old_q   <= pc_old_d;
         ir_q       <= ir_d;
         instret_q  <= instret_d;
         fetch_q    <= fetch_d;
         taken_q    <= taken_d;
         misalign_q <= misalign_d;
      end
   end

   pc_ir_unit_imm_gen u_imm_gen (
      .instr_i (instr),
      .imm_o   (bus.imm)
   );

   assign bus.pc           = pc_q;
   assign bus.pc_old       = pc_old_q;
   assign bus.instr        = instr;
   assign bus.opcode       = instr[6:0];
   assign bus.funct3       = instr[14:12];
   assign bus.funct7       = instr[31:25];
   assign bus.rs1          = instr[19:15];
   assign bus.rs2          = instr[24:20];
   assign bus.rd           = instr[11:7];
   assign bus.taken        = taken_q;
   assign bus.misalign_err = misalign_q;
   assign bus.instret      = instret_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed and randomized bench for pc_ir_unit against an arithmetic reference model.
module tb_pc_ir_unit;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   pc_ir_unit_if bus ();

   pc_ir_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] m_pc, m_pc_old, m_ir, m_instret;
   bit          m_fetch, m_taken, m_mis;

   function automatic logic [31:0] ref_imm(input logic [31:0] w);
      int sw;
      int v;
      sw = int'(w);
      case (sw & 127)
         'h13, 'h03, 'h67: v = sw >>> 20;
         'h23: v = ((sw >>> 25) * 32) + ((sw >> 7) & 31);
         'h63: v = ((sw >>> 31) * 4096) + (((sw >> 7) & 1) * 2048)
                   + (((sw >> 25) & 63) * 32) + (((sw >> 8) & 15) * 2);
         'h37, 'h17: v = sw & 32'hFFFF_F000;
         'h6f: v = ((sw >>> 31) * 1048576) + (((sw >> 12) & 255) * 4096)
                   + (((sw >> 20) & 1) * 2048) + (((sw >> 21) & 1023) * 2);
         default: v = 0;
      endcase
      return v;
   endfunction

   function automatic bit ref_cond(input logic [31:0] w, input bit z, input bit lt, input bit ltu);
      case ((w >> 12) & 7)
         0: return z;
         1: return !z;
         4: return lt;
         5: return !lt;
         6: return ltu;
         7: return !ltu;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_pc_old = 32'h0; m_ir = 32'h13; m_instret = 0;
      m_fetch = 0; m_taken = 0; m_mis = 0;
   endtask

   task automatic model_edge();
      logic [31:0] cur;
      bit c;
      bit load;
      cur  = m_fetch ? bus.mem_rd_data : m_ir;
      c    = ref_cond(cur, bus.alu_zero, bus.alu_lt, bus.alu_ltu);
      load = 0;
      if (bus.inst_en) begin
         m_pc_old  = m_pc;
         m_instret = m_instret + 1;
      end
      if (m_fetch) m_ir = bus.mem_rd_data;
      m_fetch = bus.inst_en;
      if (bus.pc_update) begin
         load = 1;
         if (bus.branch) m_taken = 0;
      end else if (bus.branch) begin
         m_taken = c;
         load = c;
      end
      if (load) begin
         m_pc = (bus.result / 4) * 4;
         if (bus.result[1]) m_mis = 1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] ei;
      ei = m_fetch ? bus.mem_rd_data : m_ir;
      chk("pc", bus.pc, m_pc);
      chk("pc_old", bus.pc_old, m_pc_old);
      chk("instr", bus.instr, ei);
      chk("opcode", {25'b0, bus.opcode}, ei & 32'h7F);
      chk("funct3", {29'b0, bus.funct3}, (ei >> 12) & 7);
      chk("funct7", {25'b0, bus.funct7}, ei >> 25);
      chk("rs1", {27'b0, bus.rs1}, (ei >> 15) & 31);
      chk("rs2", {27'b0, bus.rs2}, (ei >> 20) & 31);
      chk("rd", {27'b0, bus.rd}, (ei >> 7) & 31);
      chk("imm", bus.imm, ref_imm(ei));
      chk("taken", {31'b0, bus.taken}, {31'b0, m_taken});
      chk("misalign_err", {31'b0, bus.misalign_err}, {31'b0, m_mis});
      chk("instret", bus.instret, m_instret);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      bus.pc_update = 0; bus.branch = 0; bus.inst_en = 0;
      bus.alu_zero = 0; bus.alu_lt = 0; bus.alu_ltu = 0;
   endtask

   task automatic fetch(input logic [31:0] w, input logic [31:0] nxt);
      idle();
      bus.inst_en = 1; bus.pc_update = 1; bus.result = nxt;
      tick();
      idle();
      bus.mem_rd_data = w;
      #1 check_all();
      tick();
      bus.mem_rd_data = $urandom;
      #1 check_all();
   endtask

   task automatic do_branch(input bit z, input bit lt, input bit ltu, input logic [31:0] tgt);
      idle();
      bus.branch = 1; bus.alu_zero = z; bus.alu_lt = lt; bus.alu_ltu = ltu; bus.result = tgt;
      tick();
      idle();
      #1 check_all();
   endtask

   logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f};

   initial begin
      idle();
      bus.result = 0;
      bus.mem_rd_data = 32'hDEAD_BEEF;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1;
      #1 check_all();
      chk("rst_pc", bus.pc, 32'h0);
      chk("rst_instr", bus.instr, 32'h0000_0013);
      chk("rst_instret", bus.instret, 32'h0);

      // FETCH with simultaneous pc_update, then DECODE bypass, then IR hold.
      bus.inst_en = 1; bus.pc_update = 1; bus.result = 32'h4;
      tick();
      idle();
      bus.mem_rd_data = 32'h0050_0093;
      #1 check_all();
      chk("fetch_pc", bus.pc, 32'h4);
      chk("fetch_pc_old", bus.pc_old, 32'h0);
      chk("decode_instr", bus.instr, 32'h0050_0093);
      chk("decode_opcode", {25'b0, bus.opcode}, 32'h13);
      chk("decode_imm", bus.imm, 32'h5);
      chk("decode_rd", {27'b0, bus.rd}, 32'h1);
      chk("fetch_instret", bus.instret, 32'h1);
      tick();
      bus.mem_rd_data = 32'hDEAD_BEEF;
      #1 check_all();
      chk("ir_latched", bus.instr, 32'h0050_0093);

      // BNE taken then not taken.
      fetch(32'h0020_9463, 32'h8);
      do_branch(0, 0, 0, 32'h100);
      chk("bne_pc", bus.pc, 32'h100);
      chk("bne_taken", {31'b0, bus.taken}, 32'h1);
      do_branch(1, 0, 0, 32'h180);
      chk("bne_nt_pc", bus.pc, 32'h100);
      chk("bne_nt_taken", {31'b0, bus.taken}, 32'h0);

      // BLTU vs BLT on the same flags, then non-branch funct3.
      fetch(32'h0020_6463, 32'h104);
      do_branch(0, 0, 1, 32'h300);
      chk("bltu_pc", bus.pc, 32'h300);
      fetch(32'h0020_4463, 32'h304);
      do_branch(0, 0, 1, 32'h400);
      chk("blt_pc", bus.pc, 32'h304);
      chk("blt_taken", {31'b0, bus.taken}, 32'h0);
      fetch(32'h0020_2463, 32'h308);
      do_branch(1, 1, 1, 32'h500);
      chk("f3_010_pc", bus.pc, 32'h308);

      // Misaligned PC load, then sticky across an aligned load.
      idle(); bus.pc_update = 1; bus.result = 32'h203;
      tick(); idle();
      #1 check_all();
      chk("jalr_pc", bus.pc, 32'h200);
      chk("misalign_set", {31'b0, bus.misalign_err}, 32'h1);
      bus.pc_update = 1; bus.result = 32'h400;
      tick(); idle();
      #1 check_all();
      chk("misalign_sticky", {31'b0, bus.misalign_err}, 32'h1);

      // Immediate sweep in DECODE.
      idle(); bus.inst_en = 1; bus.pc_update = 1; bus.result = 32'h404;
      tick(); idle();
      bus.mem_rd_data = 32'hFE00_0EE3;
      #1 chk("imm_btype", bus.imm, 32'hFFFF_FFFC);
      bus.mem_rd_data = 32'h0000_006F;
      #1 chk("imm_jtype", bus.imm, 32'h0);
      bus.mem_rd_data = 32'h1234_5037;
      #1 chk("imm_lui", bus.imm, 32'h1234_5000);
      check_all();
      tick();

      // Reset asserted during a taken BRANCH cycle.
      fetch(32'h0000_0063, 32'h408);
      idle(); bus.branch = 1; bus.alu_zero = 1; bus.result = 32'h600;
      @(negedge clk);
      reset = 0;
      model_reset();
      #1 check_all();
      chk("rst_mid_pc", bus.pc, 32'h0);
      @(posedge clk); #1;
      chk("rst_hold_pc", bus.pc, 32'h0);
      chk("rst_hold_mis", {31'b0, bus.misalign_err}, 32'h0);
      @(negedge clk);
      idle();
      reset = 1;
      #1 check_all();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         bus.inst_en     = ($urandom_range(0, 3) == 0);
         bus.pc_update   = ($urandom_range(0, 4) == 0);
         bus.branch      = ($urandom_range(0, 2) == 0);
         bus.alu_zero    = $urandom_range(0, 1);
         bus.alu_lt      = $urandom_range(0, 1);
         bus.alu_ltu     = $urandom_range(0, 1);
         bus.result      = (i < 200) ? ($urandom & 32'hFFFF_FFF1) : $urandom;
         bus.mem_rd_data = {$urandom_range(0, 32'h1FF_FFFF), ops[$urandom_range(0, 9)]};
         #1 check_all();
         tick();
         check_all();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
